uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter for the Bluetooth link. It serialises words of configurable width with optional parity and one or two stop bits, LSB first, at a baud rate set by a clock-cycle divisor. A one-word holding register allows back-to-back frames with no idle gap between stop and start. It replaces the fixed 8N1 transmitter and drives the HC-05 RX pin directly from the `clk_in` domain.

## Interface
- `CLKS_PER_BIT`, 5208: `clk_in` cycles per bit (50 MHz / 9600). Legal range is ≥ 2.
- `DATA_BITS`, 8: data bits per frame. Legal range is 5..9.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk_in`  input  1: system clock.
- `reset`  input  1: active-high reset, synchronous to `clk_in`.
- `rw`  input  1: write strobe; `din` is sampled when `rw`=1.
- `din`  input  DATA_BITS: word to transmit.
- `ready`  output  1: holding register empty; a write this cycle will be accepted.
- `busy`  output  1: frame in progress or holding register full.
- `done`  output  1: one-cycle pulse on the last cycle of the final stop bit.
- `overrun`  output  1: one-cycle pulse when `rw`=1 while `ready`=0.
- `tx`  output  1: serial line, registered, idle high.

## Operation
- Reset values: `tx`=1, `ready`=1, `busy`=0, `done`=0, `overrun`=0, FSM in IDLE, holding register empty, baud counter 0.
- **Write accept**
  - If `rw`=1 and `ready`=1, `din` is loaded into the holding register and the holding register becomes full.
  - If `rw`=1 and `ready`=0, the write is dropped, `overrun` pulses on the next cycle, and the holding and shifter contents are unchanged.
  - `ready` is registered. A write that arrives in the same cycle the shifter drains the holding register is still rejected.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the holding register is full. The word moves to the shifter, the holding register empties, and the baud counter is cleared.
  - START: `tx`=0 for one bit time, then → DATA.
  - DATA: `tx`=`shift[0]`, shifting right once per bit time. After DATA_BITS bits: → PARITY if PARITY_MODE≠0, otherwise → STOP.
  - PARITY: `tx` = XOR of all data bits for even parity, or its inverse for odd parity. Parity is computed at load time, never from the shifted register. After one bit time → STOP.
  - STOP: `tx`=1 for STOP_BITS bit times. At the end, `done` pulses. Then → START directly if the holding register is full, else → IDLE.
- Bit counter width is clog2(DATA_BITS+1). Stop counter is 1 bit.
- Illegal state encoding → IDLE with `tx`=1.
- `busy` = (state≠IDLE) | holding_full.
- **Reset mid-frame:** `tx` returns to 1 on the next edge, no `done` pulse, and any held word is discarded.

## Timing
- Every bit lasts exactly CLKS_PER_BIT cycles. The baud tick fires when the counter reaches CLKS_PER_BIT−1; the counter then wraps to 0.
- Tick phase is realigned at every frame start, so there is no drift or jitter between frames.
- **Latency:** `rw` sampled at edge N with the FSM in IDLE → holding register full after N → START and `tx`=0 after N+1. The start bit's first cycle follows edge N+1.
- Frame length = (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Back-to-back:** with the holding register full at the end of STOP, the next start bit begins on the cycle immediately after the `done` cycle. There is no extra idle cycle.
- `ready` rises on the cycle after the shifter takes the word, i.e. in the first cycle of START. The next word can therefore be queued for a full frame time.
- `done` and `overrun` are never held longer than one cycle.

## Structure
- Shared header `uart_defs.vh` holds:
  - state encodings (3-bit): `ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`
  - parity constants: `PAR_NONE`=0, `PAR_EVEN`=1, `PAR_ODD`=2
- This header will be reused by the matching receiver.
- One sub-module, `baud_tick_gen`:
  - parameter `CLKS_PER_BIT`
  - inputs `clk_in`, `reset`, `clear`
  - output `tick`, a one-cycle pulse
- It replaces the free-running divider, so frame alignment is exact.
- Holding register, shifter, parity and FSM all live in `uart_tx_param`.

## Test plan
All scenarios use CLKS_PER_BIT=4 unless stated.
- **8N1:** 8N1, `din`=8'hA5, single `rw` → `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `done` pulses once, at cycle 40 of the frame.
- **Even parity:** 8E1, `din`=8'h07 → parity bit 1. Same test with 8O1 → parity bit 0. 7E2, `din`=7'h00 → parity 0 followed by two stop bits, frame = 44 cycles.
- **Back-to-back:** write 8'h55, then write 8'hAA once `ready` rises → the second start bit begins exactly 1 cycle after the first `done`. `busy` stays 1 throughout. `ready` drops twice.
- **Overrun:** with the holding register full, pulse `rw` with 8'hFF → one `overrun` pulse. The transmitted frames are only the two queued words, unchanged.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → `tx`=1 on the next edge, no `done`, `ready`=1, `busy`=0. A following write transmits a clean frame.
- **Long divisor:** CLKS_PER_BIT=5208, 9N1, `din`=9'h1FF → bit width 5208 cycles, frame = 57288 cycles.

Source files
------------

// File: rtl/uart_tx_param_pkg.sv
// uart_tx_param_pkg
// Shared UART definitions, meant to be imported by both the transmitter and
// the matching receiver.
//   state_e   : 3-bit frame FSM encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_*     : PARITY_MODE values (none / even / odd)
//   frame_len : helper giving the bit-times in one frame for a configuration
package uart_tx_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Bit-times per frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int data_bits, input int parity_mode,
                                     input int stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_param_baud_tick_gen.sv
// baud_tick_gen
// Bit-time divisor. Counts clk_in cycles and emits a one-cycle tick on the
// last cycle of every bit time. 'clear' restarts the count so the first tick
// of a frame lands exactly CLKS_PER_BIT cycles after the frame starts.
//   clk_in : system clock
//   reset  : synchronous active-high reset
//   clear  : restart the bit-time count on the next edge
//   tick   : high while the counter sits at CLKS_PER_BIT-1
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk_in) begin
        if (reset || clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity, one or two stop bits. A one-word holding register
// lets the next word be queued during a frame so frames run back to back.
//   clk_in  : system clock            reset   : synchronous active-high reset
//   rw      : write strobe            din     : word to transmit
//   ready   : holding register empty  busy    : frame running or word held
//   done    : last cycle of the final stop bit
//   overrun : write attempted while not ready (pulses on the following cycle)
//   tx      : registered serial line, idle high
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 rw,
    input  logic [DATA_BITS-1:0] din,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic                 tx
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);
    localparam logic HAS_PAR   = (PARITY_MODE != PAR_NONE);
    localparam logic ODD_PAR   = (PARITY_MODE == PAR_ODD);

    state_e               state_q;
    logic [DATA_BITS-1:0] hold_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 hold_full_q;
    logic                 hold_full_d;
    logic                 par_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 overrun_q;

    logic tick;
    logic accept;
    logic frame_end;
    logic start_from_idle;
    logic take;

    assign accept          = rw & ready_q;
    assign frame_end       = (state_q == ST_STOP) & tick & (stop_cnt_q == STOP_LAST);
    assign start_from_idle = (state_q == ST_IDLE) & hold_full_q;
    // The shifter takes the held word either from IDLE or straight out of the
    // final stop bit, which is what gives gap-free back-to-back frames.
    assign take            = start_from_idle | (frame_end & hold_full_q);

    always_comb begin
        hold_full_d = hold_full_q;
        if (take) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_full_d = 1'b1;
        end
    end

    // Only a start from IDLE needs realignment; out of STOP the counter has
    // just wrapped on the tick, so the new frame is already in phase.
    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_in(clk_in),
        .reset (reset),
        .clear (start_from_idle),
        .tick  (tick)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            ready_q     <= ~hold_full_d;
            // Guarded by its own state so a held-high rw cannot stretch it.
            overrun_q   <= rw & ~ready_q & ~overrun_q;
            if (accept) begin
                hold_q <= din;
            end
            if (take) begin
                shift_q <= hold_q;
                // Parity comes from the whole word at load, not the shifter.
                par_q   <= (^hold_q) ^ ODD_PAR;
            end
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (hold_full_q) begin
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            if (HAS_PAR) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q    <= ST_STOP;
                                stop_cnt_q <= 1'b0;
                                tx_q       <= 1'b1;
                            end
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state_q    <= ST_STOP;
                        stop_cnt_q <= 1'b0;
                        tx_q       <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            if (hold_full_q) begin
                                state_q <= ST_START;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // done is decoded from registered state and the tick so it lands on the
    // last cycle of the stop bit rather than one cycle late.
    assign done    = frame_end;
    assign ready   = ready_q;
    assign busy    = (state_q != ST_IDLE) | hold_full_q;
    assign overrun = overrun_q;
    assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
// Directed bench: five transmitter configurations share one clock, each with
// its own strobe/data/reset. Expected frames are written out by hand as bit
// vectors (bit 0 = start bit, sent first).
module tb_uart_tx_param;

    localparam int N_DUT = 5;
    // 0: 8N1/4  1: 8E1/4  2: 8O1/4  3: 7E2/4  4: 9N1/5208
    localparam int CPB_P [N_DUT] = '{4, 4, 4, 4, 5208};
    localparam int DB_P  [N_DUT] = '{8, 8, 8, 7, 9};
    localparam int PM_P  [N_DUT] = '{0, 1, 2, 1, 0};
    localparam int SB_P  [N_DUT] = '{1, 1, 1, 2, 1};

    logic                  clk;
    logic [N_DUT-1:0]      rst;
    logic [N_DUT-1:0]      rw;
    logic [N_DUT-1:0][8:0] din_a;
    logic [N_DUT-1:0]      ready_w;
    logic [N_DUT-1:0]      busy_w;
    logic [N_DUT-1:0]      done_w;
    logic [N_DUT-1:0]      overrun_w;
    logic [N_DUT-1:0]      tx_w;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
            uart_tx_param #(
                .CLKS_PER_BIT(CPB_P[gi]),
                .DATA_BITS   (DB_P[gi]),
                .PARITY_MODE (PM_P[gi]),
                .STOP_BITS   (SB_P[gi])
            ) u_dut (
                .clk_in (clk),
                .reset  (rst[gi]),
                .rw     (rw[gi]),
                .din    (din_a[gi][DB_P[gi]-1:0]),
                .ready  (ready_w[gi]),
                .busy   (busy_w[gi]),
                .done   (done_w[gi]),
                .overrun(overrun_w[gi]),
                .tx     (tx_w[gi])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge after the accepting edge (FSM still IDLE).
    task automatic send(input int idx, input logic [8:0] val);
        @(negedge clk);
        din_a[idx] = val;
        rw[idx]    = 1'b1;
        @(negedge clk);
        rw[idx]    = 1'b0;
    endtask

    task automatic check_idle(input int idx, input string tag);
        check_eq({tag, "_tx"},    tx_w[idx],      1'b1);
        check_eq({tag, "_busy"},  busy_w[idx],    1'b0);
        check_eq({tag, "_ready"}, ready_w[idx],   1'b1);
        check_eq({tag, "_done"},  done_w[idx],    1'b0);
    endtask

    // Samples cycles skip..nbits*cpb-1 of a frame (cycle 0 = first start-bit
    // cycle). Each bit must hold one level for its whole bit time; done must
    // appear exactly once, on the final cycle; busy must never drop.
    task automatic run_frame(input int idx, input int cpb, input logic [15:0] bits,
                             input int nbits, input int skip, input string tag);
        int         n_cyc;
        int         done_cnt;
        int         done_pos;
        logic       busy_ok;
        logic [1:0] seen;
        n_cyc    = nbits * cpb;
        done_cnt = 0;
        done_pos = -1;
        busy_ok  = 1'b1;
        seen     = 2'b00;
        for (int k = skip; k < n_cyc; k++) begin
            @(negedge clk);
            if (k % cpb == 0) seen = 2'b00;
            if (tx_w[idx]) seen[1] = 1'b1;
            else           seen[0] = 1'b1;
            if (done_w[idx]) begin
                done_cnt++;
                done_pos = k;
            end
            if (!busy_w[idx]) busy_ok = 1'b0;
            if (k % cpb == cpb - 1)
                check_eq($sformatf("%s_bit%0d", tag, k / cpb), seen,
                         bits[k / cpb] ? 2'b10 : 2'b01);
        end
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_done_pos"}, done_pos, n_cyc - 1);
        check_eq({tag, "_busy_hold"}, busy_ok, 1'b1);
        $display("frame %s dut=%0d bits=%0d cycles=%0d done_at=%0d",
                 tag, idx, nbits, n_cyc, done_pos + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tx_ok;
        logic no_done;

        rst   = '1;
        rw    = '0;
        din_a = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx",      tx_w[0],      1'b1);
        check_eq("rst_ready",   ready_w[0],   1'b1);
        check_eq("rst_busy",    busy_w[0],    1'b0);
        check_eq("rst_done",    done_w[0],    1'b0);
        check_eq("rst_overrun", overrun_w[0], 1'b0);
        rst = '0;
        @(negedge clk);
        check_idle(0, "post_rst");

        // 8N1, A5 -> 0,1,0,1,0,0,1,0,1,1
        send(0, 9'h0A5);
        check_eq("8n1_ready_low", ready_w[0], 1'b0);
        check_eq("8n1_busy_high", busy_w[0],  1'b1);
        check_eq("8n1_tx_pre",    tx_w[0],    1'b1);
        run_frame(0, 4, 16'b11_0100_1010, 10, 0, "8n1_a5");
        @(negedge clk);
        check_idle(0, "8n1_end");

        // Parity: 07 has three ones -> even parity 1, odd parity 0.
        send(1, 9'h007);
        run_frame(1, 4, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0, "8e1_07");
        send(2, 9'h007);
        run_frame(2, 4, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0, "8o1_07");
        // 7E2, 00 -> parity 0, two stop bits, 44 cycles.
        send(3, 9'h000);
        run_frame(3, 4, {5'b0, 2'b11, 1'b0, 7'h00, 1'b0}, 11, 0, "7e2_00");
        @(negedge clk);
        check_idle(3, "7e2_end");

        // Back-to-back: queue AA as soon as ready rises.
        send(0, 9'h055);
        check_eq("b2b_ready_drop1", ready_w[0], 1'b0);
        @(negedge clk);
        check_eq("b2b_ready_rise", ready_w[0], 1'b1);
        check_eq("b2b_start0",     tx_w[0],    1'b0);
        din_a[0] = 9'h0AA;
        rw[0]    = 1'b1;
        @(negedge clk);
        rw[0]    = 1'b0;
        check_eq("b2b_ready_drop2", ready_w[0], 1'b0);
        check_eq("b2b_busy",        busy_w[0],  1'b1);
        run_frame(0, 4, {5'b0, 1'b1, 8'h55, 1'b0}, 10, 2, "b2b_55");
        run_frame(0, 4, {5'b0, 1'b1, 8'hAA, 1'b0}, 10, 0, "b2b_aa");
        @(negedge clk);
        check_idle(0, "b2b_end");

        // Overrun with a full holding register: FF must be dropped.
        send(0, 9'h055);
        @(negedge clk);
        din_a[0] = 9'h0AA;
        rw[0]    = 1'b1;
        @(negedge clk);
        check_eq("ovr_none_on_accept", overrun_w[0], 1'b0);
        check_eq("ovr_ready_low",      ready_w[0],   1'b0);
        din_a[0] = 9'h0FF;
        @(negedge clk);
        rw[0]    = 1'b0;
        check_eq("ovr_pulse", overrun_w[0], 1'b1);
        @(negedge clk);
        check_eq("ovr_one_cycle", overrun_w[0], 1'b0);
        run_frame(0, 4, {5'b0, 1'b1, 8'h55, 1'b0}, 10, 4, "ovr_55");
        run_frame(0, 4, {5'b0, 1'b1, 8'hAA, 1'b0}, 10, 0, "ovr_aa");
        @(negedge clk);
        check_idle(0, "ovr_end");

        // Write landing on the drain edge is rejected even though the
        // register empties at that same edge.
        send(0, 9'h03C);
        din_a[0] = 9'h0FF;
        rw[0]    = 1'b1;
        @(negedge clk);
        rw[0]    = 1'b0;
        check_eq("drain_overrun", overrun_w[0], 1'b1);
        check_eq("drain_ready",   ready_w[0],   1'b1);
        run_frame(0, 4, {5'b0, 1'b1, 8'h3C, 1'b0}, 10, 1, "drain_3c");
        @(negedge clk);
        check_idle(0, "drain_end");

        // Reset during data bit 3 with a word also held.
        send(0, 9'h0A5);
        @(negedge clk);
        din_a[0] = 9'h0FF;
        rw[0]    = 1'b1;
        @(negedge clk);
        rw[0]    = 1'b0;
        repeat (16) @(negedge clk);
        check_eq("rmid_data3", tx_w[0], 1'b0);
        rst[0] = 1'b1;
        @(negedge clk);
        check_eq("rmid_tx",    tx_w[0],    1'b1);
        check_eq("rmid_ready", ready_w[0], 1'b1);
        check_eq("rmid_busy",  busy_w[0],  1'b0);
        check_eq("rmid_done",  done_w[0],  1'b0);
        rst[0] = 1'b0;
        tx_ok   = 1'b1;
        no_done = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!tx_w[0])  tx_ok = 1'b0;
            if (done_w[0]) no_done = 1'b0;
        end
        check_eq("rmid_quiet_tx",   tx_ok,   1'b1);
        check_eq("rmid_quiet_done", no_done, 1'b1);
        send(0, 9'h081);
        run_frame(0, 4, {5'b0, 1'b1, 8'h81, 1'b0}, 10, 0, "rmid_81");
        @(negedge clk);
        check_idle(0, "rmid_end");

        // Long divisor: 9N1, 1FF, 5208 cycles per bit, 57288-cycle frame.
        send(4, 9'h1FF);
        run_frame(4, 5208, {5'b0, 1'b1, 9'h1FF, 1'b0}, 11, 0, "9n1_long");
        @(negedge clk);
        check_idle(4, "9n1_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
